// File: rtl/alu_issue_queue.sv
// -----------------------------------------------------------------------------
// alu_issue_queue
//
// Out-of-order issue queue in front of a single ALU. Dispatched ops wait in a
// DEPTH-entry buffer until both source operands are available. Each cycle one
// eligible op is registered onto the issue outputs with enable=1, and its
// entry is freed. Writeback wakeups and commit-register kills are applied to
// every waiting entry.
//
// Configuration macro: ALUQ_OLDEST_FIRST_EN
//   defined   : pick the oldest eligible entry, tracked with a DEPTH x DEPTH
//               age matrix
//   undefined : pick the lowest-index eligible entry (no age state)
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   in_valid/in_ready    dispatch handshake (in_ready = queue not full)
//   in_*                 op fields captured on dispatch
//   wb_valid/wb_rd       ALU result wakeup
//   commit_kill          per-commit-register kill mask
//   enable               issue strobe to the ALU
//   control..rv32        registered fields of the issued op
//   rs1_addr/rs2_addr    register-file read addresses, valid with enable
//   count                number of occupied entries
// -----------------------------------------------------------------------------
module alu_issue_queue #(
  parameter int CNTRL_SIZE = 7,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int VA_SZ      = 48,
  parameter int DEPTH      = 8,
  parameter int LDEPTH     = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CNTRL_SIZE-1:0] in_control,
  input  logic [LNCOMMIT-1:0]   in_rd,
  input  logic                  in_makes_rd,
  input  logic                  in_needs_rs2,
  input  logic [LNCOMMIT-1:0]   in_rs1,
  input  logic [LNCOMMIT-1:0]   in_rs2,
  input  logic                  in_rs1_rdy,
  input  logic                  in_rs2_rdy,
  input  logic [VA_SZ-2:0]      in_pc,
  input  logic [31:0]           in_immed,
  input  logic                  in_rv32,
  input  logic                  wb_valid,
  input  logic [LNCOMMIT-1:0]   wb_rd,
  input  logic [NCOMMIT-1:0]    commit_kill,
  output logic                  enable,
  output logic [CNTRL_SIZE-1:0] control,
  output logic [LNCOMMIT-1:0]   rd,
  output logic                  makes_rd,
  output logic                  needs_rs2,
  output logic [VA_SZ-2:0]      pc,
  output logic [31:0]           immed,
  output logic                  rv32,
  output logic [LNCOMMIT-1:0]   rs1_addr,
  output logic [LNCOMMIT-1:0]   rs2_addr,
  output logic [LDEPTH:0]       count
);

  localparam int CW = LDEPTH + 1;

  // Entry state
  logic [DEPTH-1:0]      valid_r;
  logic [DEPTH-1:0]      rs1_rdy_r;
  logic [DEPTH-1:0]      rs2_rdy_r;
  logic [DEPTH-1:0]      e_makes_rd_r;
  logic [DEPTH-1:0]      e_needs_rs2_r;
  logic [DEPTH-1:0]      e_rv32_r;
  logic [CNTRL_SIZE-1:0] e_control_r [DEPTH];
  logic [LNCOMMIT-1:0]   e_rd_r      [DEPTH];
  logic [LNCOMMIT-1:0]   e_rs1_r     [DEPTH];
  logic [LNCOMMIT-1:0]   e_rs2_r     [DEPTH];
  logic [VA_SZ-2:0]      e_pc_r      [DEPTH];
  logic [31:0]           e_immed_r   [DEPTH];

  logic [CW-1:0]         count_r;

  // Issue output registers
  logic                  iss_enable_r;
  logic [CNTRL_SIZE-1:0] iss_control_r;
  logic [LNCOMMIT-1:0]   iss_rd_r;
  logic                  iss_makes_rd_r;
  logic                  iss_needs_rs2_r;
  logic [VA_SZ-2:0]      iss_pc_r;
  logic [31:0]           iss_immed_r;
  logic                  iss_rv32_r;
  logic [LNCOMMIT-1:0]   iss_rs1_r;
  logic [LNCOMMIT-1:0]   iss_rs2_r;

  // Combinational control
  logic                  alloc_s;
  logic [LDEPTH-1:0]     alloc_idx_s;
  logic                  alloc_rs1_rdy_s;
  logic                  alloc_rs2_rdy_s;
  logic [DEPTH-1:0]      elig_s;
  logic [DEPTH-1:0]      kill_s;
  logic [DEPTH-1:0]      cand_s;
  logic                  issue_s;
  logic [LDEPTH-1:0]     sel_idx_s;
  logic [CW-1:0]         kill_cnt_s;
  logic [CW-1:0]         count_nxt_s;

  // Full flag is derived only from the registered occupancy count
  assign in_ready = (count_r != CW'(DEPTH));

  // Dispatch is refused when its destination is being killed this cycle
  assign alloc_s = in_valid & in_ready & ~commit_kill[in_rd];

  // Operand readiness on allocate includes a same-cycle writeback bypass;
  // an immediate-form op never waits on rs2
  assign alloc_rs1_rdy_s = in_rs1_rdy | (wb_valid & (in_rs1 == wb_rd));
  assign alloc_rs2_rdy_s = ~in_needs_rs2 | in_rs2_rdy | (wb_valid & (in_rs2 == wb_rd));

  // Lowest-index free slot; descending scan lets the lowest index win
  always_comb begin
    alloc_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_idx_s = valid_r[i] ? alloc_idx_s : LDEPTH'(i);
    end
  end

  // Per-entry eligibility and kill; a killed entry is never eligible
  always_comb begin
    elig_s = '0;
    kill_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_s[i] = valid_r[i] & commit_kill[e_rd_r[i]];
      elig_s[i] = valid_r[i] & rs1_rdy_r[i] & rs2_rdy_r[i] & ~commit_kill[e_rd_r[i]];
    end
  end

`ifdef ALUQ_OLDEST_FIRST_EN
  // age_r[i][j] = 1 means entry i was allocated before entry j
  logic [DEPTH-1:0] age_r [DEPTH];

  // Age matrix: a newly allocated entry is younger than every other entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= '0;
      end
    end else if (alloc_s) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (alloc_idx_s == LDEPTH'(j)) begin
          age_r[j] <= '0;
        end else begin
          age_r[j][alloc_idx_s] <= 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_r[i] <= age_r[i];
      end
    end
  end

  // Candidate set: eligible entries with no older eligible entry
  always_comb begin
    logic blocked_v;
    cand_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      blocked_v = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
        blocked_v = blocked_v | (elig_s[j] & age_r[j][i]);
      end
      cand_s[i] = elig_s[i] & ~blocked_v;
    end
  end
`else
  // Candidate set: every eligible entry (lowest index wins below)
  assign cand_s = elig_s;
`endif

  assign issue_s = |cand_s;

  // Lowest-index candidate
  always_comb begin
    sel_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx_s = cand_s[i] ? LDEPTH'(i) : sel_idx_s;
    end
  end

  // Occupancy update: allocate, issue and kills all land on the same edge
  always_comb begin
    kill_cnt_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      kill_cnt_s = kill_cnt_s + CW'(kill_s[i]);
    end
    count_nxt_s = count_r + CW'(alloc_s) - CW'(issue_s) - kill_cnt_s;
  end

  // Occupancy counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  // Entry valid/readiness: allocate, free on issue or kill, writeback wakeup
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r   <= '0;
      rs1_rdy_r <= '0;
      rs2_rdy_r <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_s && (alloc_idx_s == LDEPTH'(i))) begin
          valid_r[i]   <= 1'b1;
          rs1_rdy_r[i] <= alloc_rs1_rdy_s;
          rs2_rdy_r[i] <= alloc_rs2_rdy_s;
        end else if ((issue_s && (sel_idx_s == LDEPTH'(i))) || kill_s[i]) begin
          valid_r[i]   <= 1'b0;
        end else if (valid_r[i] && wb_valid) begin
          if (e_rs1_r[i] == wb_rd) begin
            rs1_rdy_r[i] <= 1'b1;
          end
          if (e_rs2_r[i] == wb_rd) begin
            rs2_rdy_r[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Entry payload, captured on allocate only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_makes_rd_r  <= '0;
      e_needs_rs2_r <= '0;
      e_rv32_r      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_control_r[i] <= '0;
        e_rd_r[i]      <= '0;
        e_rs1_r[i]     <= '0;
        e_rs2_r[i]     <= '0;
        e_pc_r[i]      <= '0;
        e_immed_r[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_s && (alloc_idx_s == LDEPTH'(i))) begin
          e_makes_rd_r[i]  <= in_makes_rd;
          e_needs_rs2_r[i] <= in_needs_rs2;
          e_rv32_r[i]      <= in_rv32;
          e_control_r[i]   <= in_control;
          e_rd_r[i]        <= in_rd;
          e_rs1_r[i]       <= in_rs1;
          e_rs2_r[i]       <= in_rs2;
          e_pc_r[i]        <= in_pc;
          e_immed_r[i]     <= in_immed;
        end
      end
    end
  end

  // Issue register: fields hold their last value when nothing issues
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_enable_r    <= 1'b0;
      iss_control_r   <= '0;
      iss_rd_r        <= '0;
      iss_makes_rd_r  <= 1'b0;
      iss_needs_rs2_r <= 1'b0;
      iss_pc_r        <= '0;
      iss_immed_r     <= '0;
      iss_rv32_r      <= 1'b0;
      iss_rs1_r       <= '0;
      iss_rs2_r       <= '0;
    end else begin
      iss_enable_r <= issue_s;
      if (issue_s) begin
        iss_control_r   <= e_control_r[sel_idx_s];
        iss_rd_r        <= e_rd_r[sel_idx_s];
        iss_makes_rd_r  <= e_makes_rd_r[sel_idx_s];
        iss_needs_rs2_r <= e_needs_rs2_r[sel_idx_s];
        iss_pc_r        <= e_pc_r[sel_idx_s];
        iss_immed_r     <= e_immed_r[sel_idx_s];
        iss_rv32_r      <= e_rv32_r[sel_idx_s];
        iss_rs1_r       <= e_rs1_r[sel_idx_s];
        iss_rs2_r       <= e_rs2_r[sel_idx_s];
      end
    end
  end

  assign enable    = iss_enable_r;
  assign control   = iss_control_r;
  assign rd        = iss_rd_r;
  assign makes_rd  = iss_makes_rd_r;
  assign needs_rs2 = iss_needs_rs2_r;
  assign pc        = iss_pc_r;
  assign immed     = iss_immed_r;
  assign rv32      = iss_rv32_r;
  assign rs1_addr  = iss_rs1_r;
  assign rs2_addr  = iss_rs2_r;
  assign count     = count_r;

endmodule

// File: tb/tb_alu_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_queue
//
// Directed stimulus with a scoreboard: each op that must issue is pushed into
// exp_q in its expected issue order; a monitor on the falling edge pops and
// compares whenever enable is high. Occupancy, in_ready and enable timing are
// checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_alu_issue_queue;

  typedef struct packed {
    logic [6:0]  control;
    logic [4:0]  rd;
    logic        makes_rd;
    logic        needs_rs2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [46:0] pc;
    logic [31:0] immed;
    logic        rv32;
  } op_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_control;
  logic [4:0]  in_rd;
  logic        in_makes_rd;
  logic        in_needs_rs2;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic        in_rs1_rdy;
  logic        in_rs2_rdy;
  logic [46:0] in_pc;
  logic [31:0] in_immed;
  logic        in_rv32;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] commit_kill;
  logic        enable;
  logic [6:0]  control;
  logic [4:0]  rd;
  logic        makes_rd;
  logic        needs_rs2;
  logic [46:0] pc;
  logic [31:0] immed;
  logic        rv32;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [3:0]  count;

  op_t exp_q[$];
  op_t mon_exp;
  op_t mon_act;
  int  checks = 0;
  int  fails  = 0;

  always #5 clk = ~clk;

  alu_issue_queue dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_control(in_control), .in_rd(in_rd), .in_makes_rd(in_makes_rd),
    .in_needs_rs2(in_needs_rs2), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rs1_rdy(in_rs1_rdy), .in_rs2_rdy(in_rs2_rdy),
    .in_pc(in_pc), .in_immed(in_immed), .in_rv32(in_rv32),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .commit_kill(commit_kill),
    .enable(enable), .control(control), .rd(rd), .makes_rd(makes_rd),
    .needs_rs2(needs_rs2), .pc(pc), .immed(immed), .rv32(rv32),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .count(count)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input int r, input int s1, input int s2, input bit nrs2);
    op_t o;
    o.control   = 7'((r * 5) + 1);
    o.rd        = 5'(r);
    o.makes_rd  = 1'b1;
    o.needs_rs2 = nrs2;
    o.rs1       = 5'(s1);
    o.rs2       = 5'(s2);
    o.pc        = 47'(r) * 47'h100 + 47'h4000;
    o.immed     = 32'hABC0_0000 | 32'(r);
    o.rv32      = o.rd[0];
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input op_t o, input bit r1, input bit r2);
    in_valid     = 1'b1;
    in_control   = o.control;
    in_rd        = o.rd;
    in_makes_rd  = o.makes_rd;
    in_needs_rs2 = o.needs_rs2;
    in_rs1       = o.rs1;
    in_rs2       = o.rs2;
    in_rs1_rdy   = r1;
    in_rs2_rdy   = r2;
    in_pc        = o.pc;
    in_immed     = o.immed;
    in_rv32      = o.rv32;
  endtask

  task automatic dispatch(input op_t o, input bit r1, input bit r2);
    drive_op(o, r1, r2);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wake(input int r);
    wb_valid = 1'b1;
    wb_rd    = 5'(r);
    tick();
    wb_valid = 1'b0;
  endtask

  // Scoreboard monitor: every issue must match the next expected op
  always @(negedge clk) begin
    if (reset_n && enable) begin
      chk("issue_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {control, rd, makes_rd, needs_rs2, rs1_addr, rs2_addr, pc, immed, rv32};
        chk("issue_fields", 128'(mon_act), 128'(mon_exp));
      end
    end
  end

  initial begin
    op_t o, fa, fb, a, b, c;
    logic [31:0] km;

    reset_n = 1'b0; in_valid = 1'b0; in_control = '0; in_rd = '0;
    in_makes_rd = 1'b0; in_needs_rs2 = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_rs1_rdy = 1'b0; in_rs2_rdy = 1'b0; in_pc = '0; in_immed = '0;
    in_rv32 = 1'b0; wb_valid = 1'b0; wb_rd = '0; commit_kill = '0;

    // Reset state
    #2;
    chk("reset_enable", 128'(enable), 128'd0);
    chk("reset_count", 128'(count), 128'd0);
    chk("reset_rd", 128'(rd), 128'd0);
    chk("reset_makes_rd", 128'(makes_rd), 128'd0);
    #10 reset_n = 1'b1;
    tick();
    chk("ready_after_reset", 128'(in_ready), 128'd1);

    // Both sources ready: issue one cycle after allocation
    o = mk(3, 1, 2, 1'b1);
    exp_q.push_back(o);
    dispatch(o, 1'b1, 1'b1);
    chk("basic_count_alloc", 128'(count), 128'd1);
    chk("basic_not_early", 128'(enable), 128'd0);
    tick();
    chk("basic_enable", 128'(enable), 128'd1);
    chk("basic_count_empty", 128'(count), 128'd0);

    // Immediate form: unready rs2 is ignored
    o = mk(4, 5, 9, 1'b0);
    exp_q.push_back(o);
    dispatch(o, 1'b1, 1'b0);
    tick();
    chk("imm_enable", 128'(enable), 128'd1);

    // Wakeup by writeback two cycles after dispatch
    o = mk(5, 4, 6, 1'b1);
    dispatch(o, 1'b0, 1'b1);
    tick();
    chk("wake_waiting", 128'(enable), 128'd0);
    exp_q.push_back(o);
    wake(4);
    chk("wake_not_early", 128'(enable), 128'd0);
    tick();
    chk("wake_enable", 128'(enable), 128'd1);

    // Same-cycle writeback bypass on allocate
    o = mk(2, 14, 9, 1'b0);
    exp_q.push_back(o);
    drive_op(o, 1'b0, 1'b1);
    wb_valid = 1'b1;
    wb_rd    = 5'd14;
    tick();
    in_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
    chk("bypass_enable", 128'(enable), 128'd1);

    // Dispatch with its rd being killed is dropped
    o = mk(1, 1, 2, 1'b1);
    commit_kill = 32'h0000_0002;
    dispatch(o, 1'b1, 1'b1);
    commit_kill = '0;
    chk("kill_dispatch_count", 128'(count), 128'd0);
    repeat (2) tick();

    // Fill to capacity, then wake one
    for (int k = 0; k < 8; k++) begin
      dispatch(mk(10 + k, 20 + k, 31, 1'b0), 1'b0, 1'b1);
    end
    chk("full_count", 128'(count), 128'd8);
    chk("full_not_ready", 128'(in_ready), 128'd0);
    dispatch(mk(18, 28, 31, 1'b0), 1'b0, 1'b1);
    chk("full_no_alloc", 128'(count), 128'd8);
    exp_q.push_back(mk(10, 20, 31, 1'b0));
    wake(20);
    tick();
    chk("after_issue_count", 128'(count), 128'd7);
    chk("after_issue_ready", 128'(in_ready), 128'd1);
    km = '0;
    for (int k = 11; k < 18; k++) begin
      km[k] = 1'b1;
    end
    commit_kill = km;
    tick();
    commit_kill = '0;
    chk("multi_kill_count", 128'(count), 128'd0);

    // Out-of-order slot allocation: rd=9 in slot 2, then rd=7, rd=8 in 0, 1
    fa = mk(20, 30, 31, 1'b0);
    fb = mk(21, 30, 31, 1'b0);
    a  = mk(9, 12, 31, 1'b0);
    b  = mk(7, 12, 31, 1'b0);
    c  = mk(8, 12, 31, 1'b0);
    dispatch(fa, 1'b0, 1'b1);
    dispatch(fb, 1'b0, 1'b1);
    dispatch(a, 1'b0, 1'b1);
    km = '0;
    km[20] = 1'b1;
    km[21] = 1'b1;
    commit_kill = km;
    tick();
    commit_kill = '0;
    chk("age_filler_kill", 128'(count), 128'd1);
    dispatch(b, 1'b0, 1'b1);
    dispatch(c, 1'b0, 1'b1);
    chk("age_count", 128'(count), 128'd3);
`ifdef ALUQ_OLDEST_FIRST_EN
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
`else
    exp_q.push_back(b);
    exp_q.push_back(c);
    exp_q.push_back(a);
`endif
    wake(12);
    repeat (4) tick();
    chk("age_drained", 128'(count), 128'd0);

    // Entry becomes ready in the same cycle its rd is killed
    o = mk(6, 13, 31, 1'b0);
    dispatch(o, 1'b0, 1'b1);
    chk("killrdy_count_before", 128'(count), 128'd1);
    wake(13);
    commit_kill = 32'h0000_0040;
    tick();
    commit_kill = '0;
    chk("killrdy_count", 128'(count), 128'd0);
    chk("killrdy_enable", 128'(enable), 128'd0);
    repeat (2) tick();

    // Reset while ops are queued and one is issuing
    for (int k = 0; k < 4; k++) begin
      dispatch(mk(22 + k, 15, 31, 1'b0), 1'b0, 1'b1);
    end
    o = mk(26, 1, 2, 1'b1);
    exp_q.push_back(o);
    dispatch(o, 1'b1, 1'b1);
    tick();
    chk("rst_enable_before", 128'(enable), 128'd1);
    chk("rst_count_before", 128'(count), 128'd4);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_enable_async", 128'(enable), 128'd0);
    chk("rst_count_async", 128'(count), 128'd0);
    #1 reset_n = 1'b1;
    tick();
    chk("rst_ready_after", 128'(in_ready), 128'd1);
    wake(15);
    repeat (4) tick();
    chk("rst_no_reissue_count", 128'(count), 128'd0);

    chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
